muldiv_unit: RTL

//  Multi-cycle RV32M multiply/divide unit: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.

---
 rtl/muldiv_pkg.sv | 32 +++
 rtl/muldiv_unit_add_and_subtract.sv | 18 +
 rtl/muldiv_unit.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 codes,
// FSM state encoding and operand-signedness helpers.
package muldiv_pkg;

    localparam logic [2:0] MUL_F3    = 3'b000;
    localparam logic [2:0] MULH_F3   = 3'b001;
    localparam logic [2:0] MULHSU_F3 = 3'b010;
    localparam logic [2:0] MULHU_F3  = 3'b011;
    localparam logic [2:0] DIV_F3    = 3'b100;
    localparam logic [2:0] DIVU_F3   = 3'b101;
    localparam logic [2:0] REM_F3    = 3'b110;
    localparam logic [2:0] REMU_F3   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // rs1 is treated as signed for MUL, MULH, MULHSU, DIV and REM.
    function automatic logic a_is_signed(input logic [2:0] f3);
        return (f3 == MUL_F3) || (f3 == MULH_F3) || (f3 == MULHSU_F3) ||
               (f3 == DIV_F3) || (f3 == REM_F3);
    endfunction

    // rs2 is treated as signed for MUL, MULH, DIV and REM.
    function automatic logic b_is_signed(input logic [2:0] f3);
        return (f3 == MUL_F3) || (f3 == MULH_F3) || (f3 == DIV_F3) || (f3 == REM_F3);
    endfunction

endpackage

// File: rtl/muldiv_unit_add_and_subtract.sv
// Ripple-style adder/subtractor: sum = x + y, or x - y when sub is set.
// carry is the carry out; during subtraction carry=1 means no borrow (x >= y).
module add_and_subtract #(
    parameter int WIDTH = 33
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    logic [WIDTH-1:0] y_eff;

    assign y_eff        = sub ? ~y : y;
    assign {carry, sum} = {1'b0, x} + {1'b0, y_eff} + (WIDTH + 1)'(sub);

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit. Operands are converted to
// magnitudes at start, one bit is processed per cycle in CALC, and the sign
// is reapplied in FIX. Divide-by-zero and signed overflow bypass the loop
// when FAST_SPECIAL is set.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter bit FAST_SPECIAL = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             kill,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH - 1){1'b0}}};

    state_t state, state_nxt;

    logic [2:0]         op;
    logic [WIDTH-1:0]   addend;   // multiplicand (MUL) or divisor (DIV) magnitude
    logic [2*WIDTH-1:0] prod;     // hi: partial product / remainder, lo: multiplier / quotient
    logic [CW-1:0]      cnt;
    logic               neg;
    logic               spec;
    logic [WIDTH-1:0]   spec_val;

    // start-time decode
    logic             a_neg, b_neg, in_div, div_zero, ovf, special, neg_in, accept;
    logic [WIDTH-1:0] a_mag, b_mag, special_val;

    assign a_neg    = a_is_signed(funct3) & a[WIDTH-1];
    assign b_neg    = b_is_signed(funct3) & b[WIDTH-1];
    assign a_mag    = a_neg ? (WIDTH'(0) - a) : a;
    assign b_mag    = b_neg ? (WIDTH'(0) - b) : b;
    assign in_div   = funct3[2];
    assign div_zero = in_div && (b == '0);
    assign ovf      = ((funct3 == DIV_F3) || (funct3 == REM_F3)) && (a == MIN_VAL) && (b == '1);
    assign special  = div_zero || ovf;
    assign special_val = div_zero ? (funct3[1] ? a : '1)
                                  : (funct3[1] ? '0 : MIN_VAL);
    // remainder takes the dividend sign; everything else the xor of signs
    assign neg_in   = (in_div && funct3[1]) ? a_neg : (a_neg ^ b_neg);
    assign accept   = (state == ST_IDLE) && start && !kill;

    // shared iteration adder: add for MUL, trial subtract for DIV
    logic             op_div;
    logic [WIDTH:0]   add_x, add_y, add_sum;
    logic             add_carry;

    assign op_div = op[2];
    assign add_x  = op_div ? {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]} : {1'b0, prod[2*WIDTH-1:WIDTH]};
    assign add_y  = (op_div || prod[0]) ? {1'b0, addend} : '0;

    add_and_subtract #(.WIDTH(WIDTH + 1)) u_addsub (
        .x     (add_x),
        .y     (add_y),
        .sub   (op_div),
        .sum   (add_sum),
        .carry (add_carry)
    );

    logic [2*WIDTH-1:0] prod_step;
    assign prod_step = op_div
        ? {(add_carry ? add_sum[WIDTH-1:0] : add_x[WIDTH-1:0]), prod[WIDTH-2:0], add_carry}
        : {add_sum, prod[WIDTH-1:1]};

    // final sign fix and half/quotient/remainder selection
    logic [2*WIDTH-1:0] prod_signed;
    logic [WIDTH-1:0]   div_sel, fix_val;

    assign prod_signed = neg ? ((2 * WIDTH)'(0) - prod) : prod;
    assign div_sel     = op[1] ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
    assign fix_val     = spec   ? spec_val
                       : op_div ? (neg ? (WIDTH'(0) - div_sel) : div_sel)
                       : (op == MUL_F3) ? prod_signed[WIDTH-1:0]
                       : prod_signed[2*WIDTH-1:WIDTH];

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // next-state and handshake outputs; kill overrides every transition
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: if (start) state_nxt = (FAST_SPECIAL && special) ? ST_DONE : ST_CALC;
            ST_CALC: begin
                busy = 1'b1;
                if (cnt == '0) state_nxt = ST_FIX;
            end
            ST_FIX: begin
                busy      = 1'b1;
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (kill) state_nxt = ST_IDLE;
    end

    // operand capture, per-bit iteration and result update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op       <= '0;
            addend   <= '0;
            prod     <= '0;
            cnt      <= '0;
            neg      <= 1'b0;
            spec     <= 1'b0;
            spec_val <= '0;
            result   <= '0;
        end else if (accept) begin
            op       <= funct3;
            addend   <= in_div ? b_mag : a_mag;
            prod     <= {{WIDTH{1'b0}}, (in_div ? a_mag : b_mag)};
            cnt      <= CW'(WIDTH - 1);
            neg      <= neg_in;
            spec     <= special;
            spec_val <= special_val;
            if (FAST_SPECIAL && special) result <= special_val;
        end else if (!kill) begin
            if (state == ST_CALC) begin
                prod <= prod_step;
                cnt  <= cnt - 1'b1;
            end
            if (state == ST_FIX) result <= fix_val;
        end
    end

endmodule
